multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle control unit for the ARM-subset processor: a single state machine sequences fetch, decode, execute, memory and writeback for data-processing, LDR/STR(B) and B/BL instructions. It adds four things to the single-cycle controller: memory wait-states via a ready handshake, a bounded wait timeout with a sticky fault, byte-lane enables for STRB, and a debug state output. It sits between the instruction register/ALU flags and the multicycle datapath muxes.

## Interface

- MEM_WAIT, 1: 1 = memory states stall on mem_ready; 0 = mem_ready ignored (treated as 1).
- TIMEOUT, 16: maximum consecutive stall cycles in one memory state before fault (≥1).
- clk  input  1  rising-edge clock (single clock domain).
- reset  input  1  asynchronous, active-low reset.
- Instr  input  32  current instruction register contents.
- ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle.
- addr_lo  input  2  ALU-result bits [1:0] (byte address) in MEMWR.
- mem_ready  input  1  memory has completed the access this cycle.
- StatusRegister  output  4  architectural {N,Z,C,V}.
- PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA  output  1 each.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  output  2 each.
- ALUControl  output  4  ALU operation.
- byteEnable  output  4  store lanes.
- branch_link  output  1  BL writeback (R14 target).
- fault  output  1  sticky memory-timeout flag.
- state  output  4  current state encoding.

## Operation

- Decode fields: op=Instr[27:26] (00 DP, 01 mem, 10 branch, 11 undefined → treated as cond-fail); I=Instr[25]; cmd=Instr[24:21]; S=Instr[20]; L/load=Instr[20]; B/byte=Instr[22]; U=Instr[23]; link=Instr[24] for branch.
- Condition: Instr[31:28] is evaluated against StatusRegister using standard ARM EQ..AL; 1111 never passes.
- States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, HALT 15.
- Transitions: FETCH→DECODE. DECODE→FETCH if cond fails, otherwise mem→MEMADR, DP I=0→EXECR, DP I=1→EXECI, branch→BRANCH. MEMADR→MEMRD if L, else MEMWR. MEMRD→MEMWB. MEMWB→FETCH. MEMWR→FETCH. EXECR/EXECI→ALUWB. ALUWB→FETCH. BRANCH→FETCH. HALT is terminal until reset.
- Stall: when MEM_WAIT=1, FETCH, MEMRD and MEMWR hold until mem_ready=1. The 16-bit-safe stall counter clears on every state change. If the counter reaches TIMEOUT with mem_ready still 0 → HALT and fault=1.
- Strobes PCWrite, IRWrite and MemWrite assert only in the cycle mem_ready=1, so they pulse exactly once per access.
- Unlisted outputs are 0 in each state:
  - FETCH: AdrSrc=0, IRWrite, ALUSrcA=1, ALUSrcB=10, ALUControl=0100, ResultSrc=10, PCWrite.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=0100, ResultSrc=10, RegSrc={op==01&~L, op==10}.
  - MEMADR: ALUSrcB=01, ImmSrc=01, ALUControl = U ? 0100 : 0010.
  - MEMRD: AdrSrc=1. MEMWB: AdrSrc=1, ResultSrc=01, RegWrite.
  - MEMWR: AdrSrc=1, MemWrite, byteEnable = B ? (0001<<addr_lo) : 1111.
  - EXECR: ALUSrcB=00, ALUControl=cmd. EXECI: ALUSrcB=01, ImmSrc=00, ALUControl=cmd.
  - ALUWB: ResultSrc=00, RegWrite unless cmd[3:2]==10 (TST/TEQ/CMP/CMN).
  - BRANCH: ALUSrcA=1, ALUSrcB=01, ImmSrc=10, ALUControl=0100, ResultSrc=10, PCWrite, RegWrite=branch_link=link.
- Flags: in EXECR/EXECI with S=1, StatusRegister is updated from ALUFlags at the clock edge. N and Z are always updated. C and V are updated only for arithmetic cmd (0010–0111, 1010, 1011); logical ops keep C and V.

## Timing

- Reset (async, active-low): state=FETCH, StatusRegister=0000, fault=0, stall counter=0. All strobes are combinational from state, so they are 0 except the FETCH-state outputs.
- Zero-wait cycle counts: DP 4, LDR 5, STR 4, B/BL 3, cond-fail 2.
- Each stall cycle adds 1 per memory state.
- Flags are visible on StatusRegister the cycle after EXECR/EXECI, which is the ALUWB cycle.
- Reset asserted mid-instruction aborts it: no write strobe may appear after reset asserts.
- When mem_ready=1 in the same cycle the counter hits TIMEOUT, the access completes and there is no fault.

## Test plan

- Reset, then ADD R1,R2,#5 (E2821005), mem_ready=1 → states 0,1,7,8,0; RegWrite only in state 8; ALUControl=0100 in 7.
- SUBS giving zero (E2521005), ALUFlags=0100 → StatusRegister=0100 in ALUWB cycle. A following BNE (1A……) → 2 cycles, no PCWrite in DECODE.
- STRB with addr_lo=10 → byteEnable=0100 in MEMWR only. STR → 1111. LDR → 5 states, RegWrite in MEMWB.
- BL (EB000010) → BRANCH with PCWrite=RegWrite=branch_link=1. B (EA000010) → branch_link=0, RegWrite=0.
- MEM_WAIT=1: mem_ready low 3 cycles in FETCH → IRWrite/PCWrite pulse once, on the 4th cycle. mem_ready held low TIMEOUT cycles → state=15, fault=1 until reset.
- Assert reset during MEMWR stall → MemWrite never pulses; state=0 and StatusRegister=0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the ARM-subset core: fetch/decode/execute/memory/writeback
// sequencing with memory wait-states, stall timeout fault and STRB byte lanes.
module multicycle_ctrl #(
  parameter bit          MEM_WAIT = 1'b1,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  addr_lo,
  input  logic        mem_ready,
  output logic [3:0]  StatusRegister,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  ALUControl,
  output logic [3:0]  byteEnable,
  output logic        branch_link,
  output logic        fault,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StHalt   = 4'd15
  } state_e;

  localparam logic [15:0] StallLimit = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  status_q, status_d;
  logic [15:0] stall_q, stall_d;
  logic        fault_q, fault_d;

  logic [1:0] op;
  logic [3:0] cmd, cond;
  logic       imm, s_bit, load, byte_op, up, link;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_pass, ready, mem_state, arith;
  logic       unused_instr;

  assign cond    = Instr[31:28];
  assign op      = Instr[27:26];
  assign imm     = Instr[25];
  assign cmd     = Instr[24:21];
  assign s_bit   = Instr[20];
  assign load    = Instr[20];
  assign byte_op = Instr[22];
  assign up      = Instr[23];
  assign link    = Instr[24];
  assign unused_instr = ^Instr[19:0];

  assign {flag_n, flag_z, flag_c, flag_v} = status_q;

  always_comb begin
    unique case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = ~flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = ~flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = ~flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = ~flag_v;
      4'h8: cond_pass = flag_c & ~flag_z;
      4'h9: cond_pass = ~flag_c | flag_z;
      4'ha: cond_pass = (flag_n == flag_v);
      4'hb: cond_pass = (flag_n != flag_v);
      4'hc: cond_pass = ~flag_z & (flag_n == flag_v);
      4'hd: cond_pass = flag_z | (flag_n != flag_v);
      4'he: cond_pass = 1'b1;
      4'hf: cond_pass = 1'b0;
    endcase
  end

  // With wait-states disabled every access completes in one cycle.
  assign ready     = mem_ready | ~MEM_WAIT;
  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign arith     = (cmd inside {[4'b0010 : 4'b0111], 4'b1010, 4'b1011});

  always_comb begin
    state_d  = state_q;
    stall_d  = '0;
    fault_d  = fault_q;
    status_d = status_q;
    unique case (state_q)
      StFetch:  if (ready) state_d = StDecode;
      StDecode: begin
        if (!cond_pass || op == 2'b11) state_d = StFetch;
        else if (op == 2'b01)          state_d = StMemAdr;
        else if (op == 2'b00)          state_d = imm ? StExecI : StExecR;
        else                           state_d = StBranch;
      end
      StMemAdr: state_d = load ? StMemRd : StMemWr;
      StMemRd:  if (ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (ready) state_d = StFetch;
      StExecR, StExecI: begin
        state_d = StAluWb;
        if (s_bit) begin
          status_d[3:2] = ALUFlags[3:2];
          if (arith) status_d[1:0] = ALUFlags[1:0];
        end
      end
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
    // A completing access always wins over the timeout.
    if (mem_state && !ready) begin
      if (stall_q >= StallLimit) begin
        state_d = StHalt;
        fault_d = 1'b1;
      end else begin
        stall_d = stall_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      status_q <= '0;
      stall_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      stall_q  <= stall_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ImmSrc      = 2'b00;
    RegSrc      = 2'b00;
    ALUControl  = 4'b0000;
    byteEnable  = 4'b0000;
    branch_link = 1'b0;
    unique case (state_q)
      StFetch: begin
        IRWrite    = ready;
        PCWrite    = ready;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 4'b0100;
        ResultSrc  = 2'b10;
      end
      StDecode: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 4'b0100;
        ResultSrc  = 2'b10;
        RegSrc     = {(op == 2'b01) && !load, op == 2'b10};
      end
      StMemAdr: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b01;
        ALUControl = up ? 4'b0100 : 4'b0010;
      end
      StMemRd: AdrSrc = 1'b1;
      StMemWb: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWr: begin
        AdrSrc     = 1'b1;
        MemWrite   = ready;
        byteEnable = byte_op ? (4'b0001 << addr_lo) : 4'b1111;
      end
      StExecR: ALUControl = cmd;
      StExecI: begin
        ALUSrcB    = 2'b01;
        ALUControl = cmd;
      end
      StAluWb: RegWrite = (cmd[3:2] != 2'b10);
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b01;
        ImmSrc      = 2'b10;
        ALUControl  = 4'b0100;
        ResultSrc   = 2'b10;
        PCWrite     = 1'b1;
        RegWrite    = link;
        branch_link = link;
      end
      default: ;
    endcase
  end

  assign state          = state_q;
  assign StatusRegister = status_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of whole instructions checked through a
// scoreboard queue, plus hand-written stall, timeout and reset sequences.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  addr_lo;
  logic        mem_ready;
  logic [3:0]  StatusRegister;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0]  ALUControl, byteEnable;
  logic        branch_link, fault;
  logic [3:0]  state;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.MEM_WAIT(1'b1), .TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .Instr          (Instr),
    .ALUFlags       (ALUFlags),
    .addr_lo        (addr_lo),
    .mem_ready      (mem_ready),
    .StatusRegister (StatusRegister),
    .PCWrite        (PCWrite),
    .IRWrite        (IRWrite),
    .RegWrite       (RegWrite),
    .MemWrite       (MemWrite),
    .AdrSrc         (AdrSrc),
    .ALUSrcA        (ALUSrcA),
    .ALUSrcB        (ALUSrcB),
    .ResultSrc      (ResultSrc),
    .ImmSrc         (ImmSrc),
    .RegSrc         (RegSrc),
    .ALUControl     (ALUControl),
    .byteEnable     (byteEnable),
    .branch_link    (branch_link),
    .fault          (fault),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // trace: visited states, 4 bits each, oldest first. *_st: one-hot masks of states
  // in which the strobe was seen. alu: ALUControl in MEMADR/EXECR/EXECI.
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [1:0]  al;
    int          cycles;
    logic [63:0] trace;
    logic [15:0] rw_st;
    logic [15:0] pcw_st;
    logic [15:0] mw_st;
    logic [15:0] be_st;
    logic [3:0]  be;
    int          link;
    logic [3:0]  alu;
    logic [3:0]  status;
  } vec_t;

  vec_t vecs[14];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_instr(input int idx, input vec_t v);
    int          n;
    bit          fin;
    logic [3:0]  st;
    logic [15:0] onehot;
    vec_t        e;
    int          o_link;
    logic [63:0] o_trace;
    logic [15:0] o_rw, o_pcw, o_mw, o_bes;
    logic [3:0]  o_be, o_alu, o_status;
    Instr     = v.instr;
    ALUFlags  = v.flags;
    addr_lo   = v.al;
    mem_ready = 1'b1;
    exp_q.push_back(v);
    n = 0; fin = 0; o_link = 0; o_trace = '0;
    o_rw = '0; o_pcw = '0; o_mw = '0; o_bes = '0; o_be = '0; o_alu = '0; o_status = '0;
    while (!fin) begin
      #1;
      st = state;
      if (n > 0 && st == 4'd0) begin
        fin = 1;
      end else if (n >= 40) begin
        total++; bad++;
        $display("FAIL v%0d_done: got no return to FETCH expected within 40 cycles", idx);
        fin = 1;
      end else begin
        onehot  = 16'd1 << st;
        o_trace = {o_trace[59:0], st};
        if (RegWrite) o_rw  = o_rw | onehot;
        if (PCWrite)  o_pcw = o_pcw | onehot;
        if (MemWrite) o_mw  = o_mw | onehot;
        if (byteEnable != 4'd0) o_bes = o_bes | onehot;
        o_be   = o_be | byteEnable;
        o_link = o_link + int'(branch_link);
        if (st == 4'd2 || st == 4'd6 || st == 4'd7) o_alu = ALUControl;
        o_status = StatusRegister;
        n++;
        @(negedge clk);
      end
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d_cycles", idx), 64'(n), 64'(e.cycles));
    check($sformatf("v%0d_trace", idx), o_trace, e.trace);
    check($sformatf("v%0d_regwrite", idx), 64'(o_rw), 64'(e.rw_st));
    check($sformatf("v%0d_pcwrite", idx), 64'(o_pcw), 64'(e.pcw_st));
    check($sformatf("v%0d_memwrite", idx), 64'(o_mw), 64'(e.mw_st));
    check($sformatf("v%0d_be_states", idx), 64'(o_bes), 64'(e.be_st));
    check($sformatf("v%0d_byteenable", idx), 64'(o_be), 64'(e.be));
    check($sformatf("v%0d_link", idx), 64'(o_link), 64'(e.link));
    check($sformatf("v%0d_alucontrol", idx), 64'(o_alu), 64'(e.alu));
    check($sformatf("v%0d_status", idx), 64'(o_status), 64'(e.status));
  endtask

  task automatic wait_state(input string name, input logic [3:0] tgt, input int max);
    int n;
    bit fin;
    n = 0; fin = 0;
    while (!fin) begin
      #1;
      if (state == tgt) begin
        fin = 1;
        total++;
      end else if (n >= max) begin
        total++; bad++;
        $display("FAIL %s: got state %0d expected state %0d within %0d cycles",
                 name, state, tgt, max);
        fin = 1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // instr, flags, addr_lo, cycles, trace, rw, pcw, mw, be_st, be, link, alu, status
    vecs[0]  = '{32'hE2821005, 4'b0000, 2'd0, 4, 64'h178,  16'h0100, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0100, 4'b0000};  // ADD imm
    vecs[1]  = '{32'hE2521005, 4'b0100, 2'd0, 4, 64'h178,  16'h0100, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0010, 4'b0100};  // SUBS -> Z
    vecs[2]  = '{32'h1A000010, 4'b0000, 2'd0, 2, 64'h01,   16'h0000, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0000, 4'b0100};  // BNE fails
    vecs[3]  = '{32'hE5C21004, 4'b0000, 2'd2, 4, 64'h125,  16'h0000, 16'h0001, 16'h0020,
                 16'h0020, 4'b0100, 0, 4'b0100, 4'b0100};  // STRB lane 2
    vecs[4]  = '{32'hE5821004, 4'b0000, 2'd2, 4, 64'h125,  16'h0000, 16'h0001, 16'h0020,
                 16'h0020, 4'b1111, 0, 4'b0100, 4'b0100};  // STR
    vecs[5]  = '{32'hE5921004, 4'b0000, 2'd0, 5, 64'h1234, 16'h0010, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0100, 4'b0100};  // LDR U=1
    vecs[6]  = '{32'hE5121004, 4'b0000, 2'd0, 5, 64'h1234, 16'h0010, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0010, 4'b0100};  // LDR U=0
    vecs[7]  = '{32'hEB000010, 4'b0000, 2'd0, 3, 64'h19,   16'h0200, 16'h0201, 16'h0000,
                 16'h0000, 4'b0000, 1, 4'b0000, 4'b0100};  // BL
    vecs[8]  = '{32'hEA000010, 4'b0000, 2'd0, 3, 64'h19,   16'h0000, 16'h0201, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0000, 4'b0100};  // B
    vecs[9]  = '{32'hE0110002, 4'b1011, 2'd0, 4, 64'h168,  16'h0100, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0000, 4'b1000};  // ANDS keeps C,V
    vecs[10] = '{32'hE3510000, 4'b0110, 2'd0, 4, 64'h178,  16'h0000, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b1010, 4'b0110};  // CMP, no writeback
    vecs[11] = '{32'h0A000010, 4'b0000, 2'd0, 3, 64'h19,   16'h0000, 16'h0201, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0000, 4'b0110};  // BEQ passes
    vecs[12] = '{32'hEC000000, 4'b0000, 2'd0, 2, 64'h01,   16'h0000, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0000, 4'b0110};  // op=11
    vecs[13] = '{32'hF2821005, 4'b0000, 2'd0, 2, 64'h01,   16'h0000, 16'h0001, 16'h0000,
                 16'h0000, 4'b0000, 0, 4'b0000, 4'b0110};  // cond 1111

    reset = 1'b0; Instr = '0; ALUFlags = '0; addr_lo = '0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_status", 64'(StatusRegister), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_pcwrite", 64'(PCWrite), 64'd1);
    check("rst_irwrite", 64'(IRWrite), 64'd1);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_memwrite", 64'(MemWrite), 64'd0);
    check("rst_alusrc", 64'({ALUSrcA, ALUSrcB}), 64'b110);
    check("rst_alucontrol", 64'(ALUControl), 64'b0100);
    check("rst_resultsrc", 64'(ResultSrc), 64'b10);
    check("rst_byteenable", 64'(byteEnable), 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_instr(i, vecs[i]);

    // FETCH stalled three cycles: fetch strobes only on the fourth.
    Instr = 32'hE2821005; ALUFlags = '0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check($sformatf("fstall%0d_state", i), 64'(state), 64'd0);
      check($sformatf("fstall%0d_irwrite", i), 64'(IRWrite), 64'(i == 3));
      check($sformatf("fstall%0d_pcwrite", i), 64'(PCWrite), 64'(i == 3));
      @(negedge clk);
    end
    #1;
    check("fstall_decode", 64'(state), 64'd1);
    wait_state("fstall_back", 4'd0, 10);

    // MEMRD stalled TIMEOUT-1 cycles, then completes without fault.
    Instr = 32'hE5921004;
    wait_state("rd_reach", 4'd3, 10);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      check($sformatf("rdstall%0d_state", i), 64'(state), 64'd3);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check("rd_last_state", 64'(state), 64'd3);
    @(negedge clk);
    #1;
    check("rd_memwb", 64'(state), 64'd4);
    check("rd_nofault", 64'(fault), 64'd0);
    wait_state("rd_back", 4'd0, 10);

    // Reset during a MEMWR stall: no store strobe, immediate FETCH with cleared flags.
    Instr = 32'hE5821004;
    wait_state("wr_reach", 4'd5, 10);
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b0;
      #1;
      check($sformatf("wrstall%0d_state", i), 64'(state), 64'd5);
      check($sformatf("wrstall%0d_memwrite", i), 64'(MemWrite), 64'd0);
      @(negedge clk);
    end
    #1 reset = 1'b0;
    #1;
    check("mrst_state", 64'(state), 64'd0);
    check("mrst_status", 64'(StatusRegister), 64'd0);
    check("mrst_memwrite", 64'(MemWrite), 64'd0);
    check("mrst_regwrite", 64'(RegWrite), 64'd0);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;

    // MEMWR held off TIMEOUT cycles: HALT with sticky fault until reset.
    Instr = 32'hE5821004;
    wait_state("to_reach", 4'd5, 10);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      #1;
      check($sformatf("to%0d_state", i), 64'(state), 64'd5);
      check($sformatf("to%0d_memwrite", i), 64'(MemWrite), 64'd0);
      check($sformatf("to%0d_fault", i), 64'(fault), 64'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("halt%0d_state", i), 64'(state), 64'd15);
      check($sformatf("halt%0d_fault", i), 64'(fault), 64'd1);
      check($sformatf("halt%0d_strobes", i), 64'({PCWrite, MemWrite, RegWrite}), 64'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check("halt_rst_state", 64'(state), 64'd0);
    check("halt_rst_fault", 64'(fault), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
